// File: rtl/shift_reg_mealy_det.sv
// Serial-in/parallel-out shift register (bidirectional shift, parallel load) with a Mealy PATTERN detector.
// match is same-cycle combinational, match_q follows one cycle later; SHREG_MATCH_CNT_EN adds a saturating match counter.
module shift_reg_mealy_det #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'h01),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             dir,
  input  logic             di,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             match,
  output logic             match_q
`ifdef SHREG_MATCH_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int             FW        = $clog2(WIDTH + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(WIDTH);
  localparam logic [FW-1:0]  FILL_ARM  = FW'(WIDTH - 1);

  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] nxt;

  // Detection looks at the post-shift value; one more shift from FILL_ARM makes every bit real data.
  always_comb begin
    nxt   = dir ? {di, q[WIDTH-1:1]} : {q[WIDTH-2:0], di};
    match = ~rst & wr & ~load & (fill >= FILL_ARM) & (nxt == PATTERN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      fill    <= '0;
      full    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      match_q <= match;
      if (load) begin
        q    <= load_data;
        fill <= FILL_FULL;
        full <= 1'b1;
      end else if (wr) begin
        q    <= nxt;
        full <= (fill >= FILL_ARM);
        if (fill != FILL_FULL) fill <= fill + FW'(1);
      end
    end
  end

`ifdef SHREG_MATCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  // Counter width only matters when the counter is built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_shift_reg_mealy_det.sv
// Scoreboard bench for shift_reg_mealy_det (WIDTH=8, PATTERN=8'h01); counter checks follow SHREG_MATCH_CNT_EN.
module tb_shift_reg_mealy_det;

  localparam logic [7:0] PAT = 8'h01;

  logic       clk = 1'b0;
  logic       rst, wr, dir, di, load, cnt_clr;
  logic [7:0] load_data;
  logic [7:0] q;
  logic       full, match, match_q;
  logic [7:0] match_cnt;
  logic [7:0] q2;
  logic       full2, match2, match_q2;
  logic [1:0] match_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       m;
    logic [7:0] q;
    logic       full;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;
  exp_t sb[$];

  // reference state
  logic [7:0] m_q;
  int         m_fill;
  int         m_cnt;
  int         m_cnt2;

  always #5 clk = ~clk;

`ifdef SHREG_MATCH_CNT_EN
  shift_reg_mealy_det #(.WIDTH(8), .PATTERN(PAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr(wr), .dir(dir), .di(di), .load(load), .load_data(load_data),
    .q(q), .full(full), .match(match), .match_q(match_q), .cnt_clr(cnt_clr), .match_cnt(match_cnt));
  shift_reg_mealy_det #(.WIDTH(8), .PATTERN(PAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .wr(wr), .dir(dir), .di(di), .load(load), .load_data(load_data),
    .q(q2), .full(full2), .match(match2), .match_q(match_q2), .cnt_clr(cnt_clr), .match_cnt(match_cnt2));
`else
  shift_reg_mealy_det #(.WIDTH(8), .PATTERN(PAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr(wr), .dir(dir), .di(di), .load(load), .load_data(load_data),
    .q(q), .full(full), .match(match), .match_q(match_q));
  assign match_cnt  = '0;
  assign match_cnt2 = '0;
  assign q2 = '0;
  assign full2 = 1'b0;
  assign match2 = 1'b0;
  assign match_q2 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cnt(input int c, input int c2);
`ifdef SHREG_MATCH_CNT_EN
    chk("match_cnt", 32'(match_cnt), 32'(c));
    chk("match_cnt_w2", 32'(match_cnt2), 32'(c2));
`else
    if (c < 0 || c2 < 0) chk("cnt_model", 32'(c), 32'(0));
`endif
  endtask

  // Called between edges with the current inputs still applied; checks the asynchronous clear.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_match", 32'(match), 32'(0));
    chk("rst_match_q", 32'(match_q), 32'(0));
    m_q = 8'h00; m_fill = 0; m_cnt = 0; m_cnt2 = 0;
    check_cnt(m_cnt, m_cnt2);
    wr = 1'b0; load = 1'b0; cnt_clr = 1'b0; di = 1'b0; dir = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic ld, input logic [7:0] ldd, input logic w,
                      input logic d, input logic b, input logic clr);
    exp_t       e;
    logic [7:0] nx;
    logic       mm;
    logic       msamp;
    load = ld; load_data = ldd; wr = w; dir = d; di = b; cnt_clr = clr;
    nx = d ? {b, m_q[7:1]} : {m_q[6:0], b};
    mm = w && !ld && (m_fill >= 7) && (nx == PAT);
    if (ld) begin
      m_q = ldd; m_fill = 8;
    end else if (w) begin
      m_q = nx;
      if (m_fill < 8) m_fill++;
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (mm) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    e.m = mm; e.q = m_q; e.full = (m_fill == 8); e.cnt = 8'(m_cnt); e.cnt2 = 2'(m_cnt2);
    sb.push_back(e);
    @(negedge clk);
    msamp = match;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("match", 32'(msamp), 32'(e.m));
    chk("q", 32'(q), 32'(e.q));
    chk("full", 32'(full), 32'(e.full));
    chk("match_q", 32'(match_q), 32'(e.m));
    check_cnt(32'(e.cnt), 32'(e.cnt2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ldv;
    wr = 1'b0; dir = 1'b0; di = 1'b0; load = 1'b0; load_data = 8'h00; cnt_clr = 1'b0;
    do_reset();

    // First shift after reset never matches even though q becomes PATTERN.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();

    // Seven zeros then a one: match on the completing shift.
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load beats wr, then right shifts walk 0x80 down to 0x01.
    step(1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Match then no stale match on the following shift.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream while a match is being presented.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; wr = 1'b1; dir = 1'b0; di = 1'b1;
    #1;
    chk("pre_rst_match", 32'(match), 32'(1));
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Counter: three matches, clear colliding with a fourth, then saturate the 2-bit instance.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    end

    // Random traffic: direction changes, sparse loads and clears, zero-biased data.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0:       ldv = 8'h00;
        1:       ldv = 8'h80;
        2:       ldv = 8'h02;
        3:       ldv = 8'h01;
        default: ldv = 8'($urandom);
      endcase
      step(($urandom_range(0, 15) == 0), ldv, ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
